menu_ctrl: RTL and testbench
============================

# menu_ctrl

Frame-synchronous screen sequencer for the menu/game display pipeline. It takes debounced button levels, a game-over event and the VGA vertical blanking signal. It owns the top-level screen state (menu, countdown, game, game-over), the highlighted menu item, and the start-of-game reset pulse. All visible changes are committed only at the start of vertical blanking, so the draw stages never switch source mid-frame.

## Interface
Parameters:
- N_ITEMS, 3 — number of menu entries; item 0 = START.
- COUNTDOWN_FRAMES, 120 — frames spent in COUNTDOWN before GAME.
- OVER_FRAMES, 300 — frames in OVER before automatic return to MENU.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vblnk  in  1  vertical blanking from VGA timing, level.
- btn_up  in  1  debounced level.
- btn_down  in  1  debounced level.
- btn_enter  in  1  debounced level.
- btn_back  in  1  debounced level.
- game_over  in  1  single-cycle event from game logic.
- screen  out  2  screen_t: MENU=0, COUNTDOWN=1, GAME=2, OVER=3; drives the draw mux.
- item_sel  out  $clog2(N_ITEMS)  highlighted menu item.
- count  out  16  frames remaining in COUNTDOWN/OVER; 0 otherwise.
- menu_act  out  1  one-cycle pulse when enter is applied to a non-START item; item_sel identifies it.
- game_rst  out  1  one-cycle pulse on entry to GAME.

## Operation
- frame_tick = vblnk & ~vblnk_q (registered previous value). This is the only commit point.
- Button press = rising edge of the level (registered previous value). A press sets a per-button pending flag.
- game_over sets the over pending flag.
- All pending flags clear on frame_tick, whether or not the current state consumed them.
- A press arriving in the same cycle as frame_tick is kept pending for the next frame.
- At frame_tick, by state; higher priority first:
  - MENU:
    - back: ignored.
    - enter with item_sel==0: go to COUNTDOWN, count=COUNTDOWN_FRAMES-1.
    - enter with item_sel≠0: pulse menu_act.
    - up and down both pending: cancel, no move.
    - up: item_sel-1, wraps 0→N_ITEMS-1.
    - down: item_sel+1, wraps N_ITEMS-1→0.
    - Up/down are evaluated even when enter is pending, but enter uses the pre-move item_sel.
  - COUNTDOWN:
    - back: MENU.
    - count==0: GAME and pulse game_rst.
    - otherwise: count-1.
  - GAME:
    - back: MENU.
    - over pending: OVER, count=OVER_FRAMES-1.
    - game_over arriving outside GAME: discarded at the next tick.
  - OVER:
    - back or enter: MENU.
    - count==0: MENU.
    - otherwise: count-1.
- Entering MENU sets item_sel=0 and count=0.
- screen is a registered copy of the state.

## Timing
- Reset values: state/screen MENU, item_sel 0, count 0, menu_act 0, game_rst 0, all pending flags 0, vblnk_q 0, button history 0.
- Buttons held high through reset do not generate a press.
- Press at cycle t → pending at t+1 → applied at the first frame_tick ≥ t+1 → outputs change in the cycle after that tick.
- menu_act and game_rst are high for exactly one cycle, aligned with the screen/item_sel update.
- COUNTDOWN lasts exactly COUNTDOWN_FRAMES ticks. OVER auto-exits after exactly OVER_FRAMES ticks.
- rst mid-operation returns to MENU on the next edge; no pulse is generated.

## Structure
- vga_pkg gains the screen_t enum (2-bit) and MENU_ITEMS_DEFAULT.
- Sub-module btn_pend: edge detect plus pending latch with clear input, instantiated per button and for game_over.
- Main FSM and counter in menu_ctrl; 2-process style (registered state, combinational next).

## Test plan
- Reset with btn_enter held high, then release: screen=0, item_sel=0, count=0, no press registered.
- btn_down pressed 4 times, one per frame, N_ITEMS=3: item_sel sequence 1,2,0,1, each update one cycle after a vblnk rise.
- item_sel=0, enter pressed: next tick screen=1, count=COUNTDOWN_FRAMES-1. Exactly COUNTDOWN_FRAMES ticks later screen=2 with a single-cycle game_rst.
- In GAME, game_over and btn_back in the same frame: screen=0 (back wins), item_sel=0, no OVER.
- In OVER, no input: screen returns to 0 after OVER_FRAMES ticks. game_over pulsed in MENU has no effect.
- item_sel=2, enter: menu_act pulses once, screen stays 0. Press in the tick cycle is applied on the following frame.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the menu/game display pipeline.
//   screen_t            - top-level screen selector driving the draw mux
//   MENU_ITEMS_DEFAULT  - default number of menu entries (item 0 = START)
package vga_pkg;

  typedef enum logic [1:0] {
    SCR_MENU      = 2'd0,
    SCR_COUNTDOWN = 2'd1,
    SCR_GAME      = 2'd2,
    SCR_OVER      = 2'd3
  } screen_t;

  localparam int MENU_ITEMS_DEFAULT = 3;

endpackage

// File: rtl/btn_pend.sv
// btn_pend: turns an input into a sticky "pending" flag that the frame
// sequencer consumes once per frame.
//   clk, rst - clock, synchronous active-high reset
//   lvl      - debounced button level (EDGE=1) or single-cycle event (EDGE=0)
//   clr      - frame commit strobe; clears the flag
//   pend     - event seen since the last commit
module btn_pend #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  input  logic clr,
  output logic pend
);

  logic prev;
  logic armed;
  logic press;

  // armed stays low for the first cycle after reset so that a button held
  // through reset is absorbed into the history instead of counting as a press.
  assign press = EDGE ? (lvl & ~prev & armed) : lvl;

  // A press in the same cycle as clr survives the clear and is served at the
  // following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      pend  <= 1'b0;
    end else begin
      prev  <= lvl;
      armed <= 1'b1;
      pend  <= press | (pend & ~clr);
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: frame-synchronous screen sequencer (menu, countdown, game,
// game-over). All visible changes commit at the rising edge of vblnk.
//   clk, rst          - pixel clock, synchronous active-high reset
//   vblnk             - vertical blanking level from VGA timing
//   btn_up/down/enter/back - debounced button levels
//   game_over         - single-cycle event from game logic
//   screen            - current screen, drives the draw mux
//   item_sel          - highlighted menu item
//   count             - frames remaining in COUNTDOWN/OVER, else 0
//   menu_act          - one-cycle pulse: enter on a non-START item
//   game_rst          - one-cycle pulse on entry to GAME
module menu_ctrl
  import vga_pkg::*;
#(
  parameter int N_ITEMS          = MENU_ITEMS_DEFAULT,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int OVER_FRAMES      = 300
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vblnk,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_enter,
  input  logic                       btn_back,
  input  logic                       game_over,
  output screen_t                    screen,
  output logic [$clog2(N_ITEMS)-1:0] item_sel,
  output logic [15:0]                count,
  output logic                       menu_act,
  output logic                       game_rst
);

  localparam int IW = $clog2(N_ITEMS);
  localparam logic [IW-1:0] LAST_ITEM = IW'(N_ITEMS - 1);
  localparam logic [15:0]   CD_LOAD   = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [15:0]   OV_LOAD   = 16'(OVER_FRAMES - 1);

  logic vblnk_q;
  logic frame_tick;
  logic up_p, down_p, enter_p, back_p, over_p;

  screen_t       state, state_n;
  logic [IW-1:0] item_q, item_n;
  logic [15:0]   count_q, count_n;
  logic          act_q, act_n;
  logic          grst_q, grst_n;

  // Blanking start is the single commit point for everything visible.
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  assign frame_tick = vblnk & ~vblnk_q;

  btn_pend #(.EDGE(1'b1)) u_up    (.clk(clk), .rst(rst), .lvl(btn_up),    .clr(frame_tick), .pend(up_p));
  btn_pend #(.EDGE(1'b1)) u_down  (.clk(clk), .rst(rst), .lvl(btn_down),  .clr(frame_tick), .pend(down_p));
  btn_pend #(.EDGE(1'b1)) u_enter (.clk(clk), .rst(rst), .lvl(btn_enter), .clr(frame_tick), .pend(enter_p));
  btn_pend #(.EDGE(1'b1)) u_back  (.clk(clk), .rst(rst), .lvl(btn_back),  .clr(frame_tick), .pend(back_p));
  btn_pend #(.EDGE(1'b0)) u_over  (.clk(clk), .rst(rst), .lvl(game_over), .clr(frame_tick), .pend(over_p));

  // Next-state logic. Outside a frame tick everything holds and the pulses
  // drop, so menu_act/game_rst are exactly one cycle wide.
  always_comb begin
    state_n = state;
    item_n  = item_q;
    count_n = count_q;
    act_n   = 1'b0;
    grst_n  = 1'b0;
    if (frame_tick) begin
      case (state)
        SCR_MENU: begin
          // Navigation is applied even with enter pending; enter below looks
          // at the pre-move item_q. Up and down together cancel.
          if (up_p && !down_p)
            item_n = (item_q == '0) ? LAST_ITEM : item_q - 1'b1;
          else if (down_p && !up_p)
            item_n = (item_q == LAST_ITEM) ? '0 : item_q + 1'b1;
          if (enter_p) begin
            if (item_q == '0) begin
              state_n = SCR_COUNTDOWN;
              count_n = CD_LOAD;
            end else begin
              act_n = 1'b1;
            end
          end
        end
        SCR_COUNTDOWN: begin
          if (back_p) begin
            state_n = SCR_MENU;
            item_n  = '0;
            count_n = '0;
          end else if (count_q == '0) begin
            state_n = SCR_GAME;
            grst_n  = 1'b1;
          end else begin
            count_n = count_q - 16'd1;
          end
        end
        SCR_GAME: begin
          if (back_p) begin
            state_n = SCR_MENU;
            item_n  = '0;
            count_n = '0;
          end else if (over_p) begin
            state_n = SCR_OVER;
            count_n = OV_LOAD;
          end
        end
        SCR_OVER: begin
          if (back_p || enter_p || count_q == '0) begin
            state_n = SCR_MENU;
            item_n  = '0;
            count_n = '0;
          end else begin
            count_n = count_q - 16'd1;
          end
        end
        default: begin
          state_n = SCR_MENU;
          item_n  = '0;
          count_n = '0;
        end
      endcase
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCR_MENU;
      item_q  <= '0;
      count_q <= '0;
      act_q   <= 1'b0;
      grst_q  <= 1'b0;
    end else begin
      state   <= state_n;
      item_q  <= item_n;
      count_q <= count_n;
      act_q   <= act_n;
      grst_q  <= grst_n;
    end
  end

  assign screen   = state;
  assign item_sel = item_q;
  assign count    = count_q;
  assign menu_act = act_q;
  assign game_rst = grst_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: self-checking bench for menu_ctrl with short frame counts.
// Each "frame" pulses the requested inputs, then raises vblnk and compares
// the committed outputs one cycle after the blanking edge.
module tb_menu_ctrl;
  import vga_pkg::*;

  localparam int N  = 3;
  localparam int CD = 5;
  localparam int OV = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vblnk = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, btn_back = 1'b0;
  logic game_over = 1'b0;
  screen_t screen;
  logic [1:0]  item_sel;
  logic [15:0] count;
  logic menu_act, game_rst;

  int nVec = 0;
  int nErr = 0;

  int lastS = 0, lastI = 0, lastC = 0;

  typedef struct {
    logic u, d, e, b, g;
    int   s, i, c;
    logic a, r;
  } vec_t;
  vec_t tbl[$];

  menu_ctrl #(.N_ITEMS(N), .COUNTDOWN_FRAMES(CD), .OVER_FRAMES(OV)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .btn_back(btn_back), .game_over(game_over),
    .screen(screen), .item_sel(item_sel), .count(count),
    .menu_act(menu_act), .game_rst(game_rst)
  );

  always #5 clk = ~clk;

  // Single comparison; every call counts as one applied vector.
  task automatic cmp(input string name, input int got, input int exp);
    nVec++;
    if (got != exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int es, input int ei,
                             input int ec, input int ea, input int er);
    cmp({name, ".screen"},   int'(screen),   es);
    cmp({name, ".item_sel"}, int'(item_sel), ei);
    cmp({name, ".count"},    int'(count),    ec);
    cmp({name, ".menu_act"}, int'(menu_act), ea);
    cmp({name, ".game_rst"}, int'(game_rst), er);
  endtask

  // One frame: pulse inputs, idle, then a blanking edge and the checks.
  task automatic applyStimulus(input string name, input logic u, d, e, b, g,
                               input int es, input int ei, input int ec,
                               input logic ea, input logic er);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_enter = e; btn_back = b; game_over = g;
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_enter = 0; btn_back = 0; game_over = 0;
    @(negedge clk);
    checkOutput({name, "/pre"}, lastS, lastI, lastC, 0, 0);
    vblnk = 1'b1;
    @(negedge clk);
    checkOutput(name, es, ei, ec, int'(ea), int'(er));
    @(negedge clk);
    cmp({name, "/post.menu_act"}, int'(menu_act), 0);
    cmp({name, "/post.game_rst"}, int'(game_rst), 0);
    vblnk = 1'b0;
    lastS = es; lastI = ei; lastC = ec;
  endtask

  function automatic void addVec(logic u, d, e, b, g, int s, int i, int c, logic a, r);
    vec_t v;
    v.u = u; v.d = d; v.e = e; v.b = b; v.g = g;
    v.s = s; v.i = i; v.c = c; v.a = a; v.r = r;
    tbl.push_back(v);
  endfunction

  int mS = 0, mI = 0, mC = 0;

  initial begin
    // Vector table: u d e b g | screen item count act rst
    addVec(0,1,0,0,0, 0,1,0, 0,0);
    addVec(0,1,0,0,0, 0,2,0, 0,0);
    addVec(0,1,0,0,0, 0,0,0, 0,0);
    addVec(0,1,0,0,0, 0,1,0, 0,0);
    addVec(0,1,0,0,0, 0,2,0, 0,0);
    addVec(0,0,1,0,0, 0,2,0, 1,0);
    addVec(1,0,0,0,0, 0,1,0, 0,0);
    addVec(1,1,0,0,0, 0,1,0, 0,0);
    addVec(1,0,0,0,0, 0,0,0, 0,0);
    addVec(1,0,0,0,0, 0,2,0, 0,0);
    addVec(0,1,0,0,0, 0,0,0, 0,0);
    addVec(0,0,0,1,0, 0,0,0, 0,0);
    addVec(0,0,0,0,1, 0,0,0, 0,0);
    addVec(0,0,1,0,0, 1,0,4, 0,0);
    addVec(0,0,0,0,0, 1,0,3, 0,0);
    addVec(1,0,0,0,0, 1,0,2, 0,0);
    addVec(0,0,0,0,0, 1,0,1, 0,0);
    addVec(0,0,0,0,0, 1,0,0, 0,0);
    addVec(0,0,0,0,0, 2,0,0, 0,1);
    addVec(0,0,0,1,1, 0,0,0, 0,0);
    addVec(0,0,1,0,0, 1,0,4, 0,0);
    for (int k = 3; k >= 0; k--) addVec(0,0,0,0,0, 1,0,k, 0,0);
    addVec(0,0,0,0,0, 2,0,0, 0,1);
    addVec(0,0,1,0,0, 2,0,0, 0,0);
    addVec(0,0,0,0,1, 3,0,6, 0,0);
    for (int k = 5; k >= 0; k--) addVec(0,0,0,0,0, 3,0,k, 0,0);
    addVec(0,0,0,0,0, 0,0,0, 0,0);
    addVec(0,0,0,0,1, 0,0,0, 0,0);
    addVec(0,1,0,0,0, 0,1,0, 0,0);
    addVec(1,0,0,0,0, 0,0,0, 0,0);
    addVec(0,0,1,0,0, 1,0,4, 0,0);
    addVec(0,0,0,1,0, 0,0,0, 0,0);
    addVec(0,0,1,0,0, 1,0,4, 0,0);
    for (int k = 3; k >= 0; k--) addVec(0,0,0,0,0, 1,0,k, 0,0);
    addVec(0,0,0,0,0, 2,0,0, 0,1);
    addVec(0,0,0,0,1, 3,0,6, 0,0);
    addVec(0,0,1,0,0, 0,0,0, 0,0);

    // Reset with enter held high through and after reset.
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0, 0);
    btn_enter = 1'b0;
    applyStimulus("heldEnter", 0,0,0,0,0, 0,0,0, 0,0);

    for (int k = 0; k < tbl.size(); k++)
      applyStimulus($sformatf("vec%0d", k), tbl[k].u, tbl[k].d, tbl[k].e,
                    tbl[k].b, tbl[k].g, tbl[k].s, tbl[k].i, tbl[k].c,
                    tbl[k].a, tbl[k].r);

    // Press whose edge coincides with the blanking edge: deferred a frame.
    @(negedge clk);
    vblnk = 1'b1;
    btn_down = 1'b1;
    @(negedge clk);
    checkOutput("tickPress", 0, 0, 0, 0, 0);
    btn_down = 1'b0;
    @(negedge clk);
    vblnk = 1'b0;
    applyStimulus("tickPressNext", 0,0,0,0,0, 0,1,0, 0,0);

    // Reset in the middle of a countdown: back to MENU, no pulses.
    applyStimulus("toZero", 1,0,0,0,0, 0,0,0, 0,0);
    applyStimulus("toCd",   0,0,1,0,0, 1,0,4, 0,0);
    applyStimulus("cdRun",  0,0,0,0,0, 1,0,3, 0,0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRst", 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("midRstHold", 0, 0, 0, 0, 0);
    lastS = 0; lastI = 0; lastC = 0;

    // Random frames against a per-frame reference model.
    mS = 0; mI = 0; mC = 0;
    for (int k = 0; k < 300; k++) begin
      logic u, d, e, b, g, ea, er;
      int ns, ni, nc;
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      g = ($urandom_range(0, 3) == 0);
      ns = mS; ni = mI; nc = mC; ea = 0; er = 0;
      case (mS)
        0: begin
          if (u && !d)      ni = (mI + N - 1) % N;
          else if (d && !u) ni = (mI + 1) % N;
          if (e) begin
            if (mI == 0) begin ns = 1; nc = CD - 1; end
            else ea = 1;
          end
        end
        1: begin
          if (b)            begin ns = 0; ni = 0; nc = 0; end
          else if (mC == 0) begin ns = 2; nc = 0; er = 1; end
          else              nc = mC - 1;
        end
        2: begin
          if (b)      begin ns = 0; ni = 0; nc = 0; end
          else if (g) begin ns = 3; nc = OV - 1; end
        end
        default: begin
          if (b || e || mC == 0) begin ns = 0; ni = 0; nc = 0; end
          else nc = mC - 1;
        end
      endcase
      applyStimulus($sformatf("rnd%0d", k), u, d, e, b, g, ns, ni, nc, ea, er);
      mS = ns; mI = ni; mC = nc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
